// File: rtl/sysid_pkg.sv
// sysid_pkg: register map, CAPS layout and shared widths for sysid_regs.
package sysid_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned CNT_W  = 64;

   // Word offsets of the register map; NUM_REGS and above are unmapped.
   localparam int unsigned REG_ID        = 0;
   localparam int unsigned REG_TIMESTAMP = 1;
   localparam int unsigned REG_CAPS      = 2;
   localparam int unsigned REG_SCRATCH   = 3;
   localparam int unsigned REG_UPTIME_LO = 4;
   localparam int unsigned REG_UPTIME_HI = 5;
   localparam int unsigned REG_CONTROL   = 6;

   // CAPS word layout.
   localparam logic [15:0] CAPS_VERSION    = 16'h0002;
   localparam int unsigned CAPS_UPTIME_BIT = 0;
   localparam int unsigned CAPS_AW_LSB     = 8;
   localparam int unsigned CAPS_VER_LSB    = 16;

   // CONTROL bit that clears the uptime counter.
   localparam int unsigned CTRL_CLR_BIT = 0;

   // Builds the CAPS word from the address width and uptime presence.
   function automatic logic [DATA_W-1:0] caps_word(input int unsigned aw, input logic uptime);
      logic [DATA_W-1:0] w;
      w                      = '0;
      w[CAPS_UPTIME_BIT]     = uptime;
      w[CAPS_AW_LSB +: 8]    = 8'(aw);
      w[CAPS_VER_LSB +: 16]  = CAPS_VERSION;
      return w;
   endfunction

endpackage

// File: rtl/sysid_uptime.sv
// sysid_uptime: 64-bit free-running counter with high-word shadow.
// Present only when SYSID_UPTIME_EN is defined; clear beats snapshot.
`ifdef SYSID_UPTIME_EN
module sysid_uptime
   import sysid_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              snap_i,
   input  logic              clr_i,
   output logic [DATA_W-1:0] cnt_lo_o,
   output logic [DATA_W-1:0] shadow_hi_o
);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shadow_q, shadow_d;

   // Next-state: clear wins over both increment and snapshot.
   always_comb begin
      cnt_d    = cnt_q + CNT_W'(1);
      shadow_d = shadow_q;
      if (clr_i) begin
         cnt_d    = '0;
         shadow_d = '0;
      end else if (snap_i) begin
         shadow_d = cnt_q[CNT_W-1:DATA_W];
      end
   end

   // Counter and shadow registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         shadow_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

   assign cnt_lo_o    = cnt_q[DATA_W-1:0];
   assign shadow_hi_o = shadow_q;

endmodule
`endif

// File: rtl/sysid_regs.sv
// sysid_regs: Avalon-MM system-ID slave (ID, timestamp, CAPS, scratch,
// optional uptime counter). Define SYSID_UPTIME_EN to include the uptime
// counter, its high shadow and the CONTROL clear.
module sysid_regs
   import sysid_pkg::*;
#(
   parameter logic [DATA_W-1:0] ID_VALUE      = 32'h0000_0000,
   parameter logic [DATA_W-1:0] TIMESTAMP     = 32'd1338190563,
   parameter int unsigned       ADDR_W        = 3,   // must be >= 3
   parameter logic [DATA_W-1:0] SCRATCH_RESET = 32'h0000_0000
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [DATA_W-1:0] writedata,
   input  logic [BE_W-1:0]   byteenable,
   output logic [DATA_W-1:0] readdata,
   output logic              readdatavalid
);

`ifdef SYSID_UPTIME_EN
   localparam logic UPTIME_PRESENT = 1'b1;
`else
   localparam logic UPTIME_PRESENT = 1'b0;
`endif
   localparam logic [DATA_W-1:0] CAPS_VALUE = caps_word(ADDR_W, UPTIME_PRESENT);

   logic [DATA_W-1:0] scratch_q, scratch_d;
   logic [DATA_W-1:0] readdata_q;
   logic              rdv_q;
   logic [DATA_W-1:0] rdata_c;
   logic [DATA_W-1:0] up_lo, up_hi;

`ifdef SYSID_UPTIME_EN
   logic snap, clr;

   // Snapshot on a UPTIME_LO read; clear on CONTROL bit0 with lane 0 enabled.
   always_comb begin
      snap = read && (address == ADDR_W'(REG_UPTIME_LO));
      clr  = write && (address == ADDR_W'(REG_CONTROL))
             && byteenable[0] && writedata[CTRL_CLR_BIT];
   end

   sysid_uptime u_uptime (
      .clk_i       (clock),
      .rst_ni      (reset_n),
      .snap_i      (snap),
      .clr_i       (clr),
      .cnt_lo_o    (up_lo),
      .shadow_hi_o (up_hi)
   );
`else
   assign up_lo = '0;
   assign up_hi = '0;
`endif

   // Scratch next-state: merge only the enabled byte lanes.
   always_comb begin
      scratch_d = scratch_q;
      if (write && (address == ADDR_W'(REG_SCRATCH))) begin
         for (int i = 0; i < int'(BE_W); i++) begin
            if (byteenable[i]) scratch_d[8*i +: 8] = writedata[8*i +: 8];
         end
      end
   end

   // Scratch register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) scratch_q <= SCRATCH_RESET;
      else          scratch_q <= scratch_d;
   end

   // Read mux over current (pre-write) register values.
   always_comb begin
      rdata_c = '0;
      case (address)
         ADDR_W'(REG_ID):        rdata_c = ID_VALUE;
         ADDR_W'(REG_TIMESTAMP): rdata_c = TIMESTAMP;
         ADDR_W'(REG_CAPS):      rdata_c = CAPS_VALUE;
         ADDR_W'(REG_SCRATCH):   rdata_c = scratch_q;
         ADDR_W'(REG_UPTIME_LO): rdata_c = up_lo;
         ADDR_W'(REG_UPTIME_HI): rdata_c = up_hi;
         ADDR_W'(REG_CONTROL):   rdata_c = '0;
         default:                rdata_c = '0;
      endcase
   end

   // Registered read path: data updates only on a read, valid pulses once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         readdata_q <= '0;
         rdv_q      <= 1'b0;
      end else begin
         rdv_q <= read;
         if (read) readdata_q <= rdata_c;
      end
   end

   assign readdata      = readdata_q;
   assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_sysid_regs.sv
// tb_sysid_regs: directed self-checking bench for sysid_regs.
// Uptime scenarios run when SYSID_UPTIME_EN is defined, otherwise the
// disabled-build behaviour is checked.
module tb_sysid_regs;

   localparam logic [31:0] ID_V = 32'hCAFE_0001;
   localparam logic [31:0] TS_V = 32'd1338190563;
`ifdef SYSID_UPTIME_EN
   localparam logic [31:0] UP_BIT = 32'h1;
`else
   localparam logic [31:0] UP_BIT = 32'h0;
`endif
   localparam logic [31:0] CAPS3 = 32'h0002_0300 | UP_BIT;
   localparam logic [31:0] CAPS4 = 32'h0002_0400 | UP_BIT;

   logic        clk, rst_n, rd, wr;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [31:0] rdata, rdata4;
   logic        rdv, rdv4;

   int errors = 0;
   int checks = 0;

   sysid_regs #(.ID_VALUE(ID_V), .TIMESTAMP(TS_V), .ADDR_W(3), .SCRATCH_RESET(32'h0)) dut (
      .clock(clk), .reset_n(rst_n), .address(addr[2:0]), .read(rd), .write(wr),
      .writedata(wdata), .byteenable(be), .readdata(rdata), .readdatavalid(rdv)
   );

   sysid_regs #(.ID_VALUE(ID_V), .TIMESTAMP(TS_V), .ADDR_W(4), .SCRATCH_RESET(32'h0)) dut4 (
      .clock(clk), .reset_n(rst_n), .address(addr), .read(rd), .write(wr),
      .writedata(wdata), .byteenable(be), .readdata(rdata4), .readdatavalid(rdv4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus tasks: called at a negedge, return at the negedge after the access edge.
   task automatic bus_read(input logic [3:0] a);
      addr = a; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
      addr = a; wdata = d; be = b; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (rdata !== 32'h0 || rdv !== 1'b0) begin
         errors++; $display("FAIL reset_outputs: rdata=%h rdv=%b required 0/0", rdata, rdv);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (rdv !== 1'b0) begin
         errors++; $display("FAIL idle_rdv: rdv=%b required 0", rdv);
      end
   endtask

   task automatic test_ids();
      bus_read(4'd0);
      checks++;
      if (rdv !== 1'b1 || rdata !== ID_V) begin
         errors++; $display("FAIL read_id: rdv=%b rdata=%h required 1/%h", rdv, rdata, ID_V);
      end
      @(negedge clk);
      checks++;
      if (rdv !== 1'b0 || rdata !== ID_V) begin
         errors++; $display("FAIL id_hold: rdv=%b rdata=%h required 0/%h", rdv, rdata, ID_V);
      end
      bus_read(4'd1);
      checks++;
      if (rdv !== 1'b1 || rdata !== TS_V) begin
         errors++; $display("FAIL read_ts: rdv=%b rdata=%h required 1/%h", rdv, rdata, TS_V);
      end
      bus_read(4'd2);
      checks++;
      if (rdv !== 1'b1 || rdata !== CAPS3) begin
         errors++; $display("FAIL read_caps: rdv=%b rdata=%h required 1/%h", rdv, rdata, CAPS3);
      end
      checks++;
      if (rdv4 !== 1'b1 || rdata4 !== CAPS4) begin
         errors++; $display("FAIL read_caps_aw4: rdv=%b rdata=%h required 1/%h", rdv4, rdata4, CAPS4);
      end
      @(negedge clk);
      checks++;
      if (rdv !== 1'b0) begin
         errors++; $display("FAIL caps_single_pulse: rdv=%b required 0", rdv);
      end
   endtask

   task automatic test_scratch();
      bus_write(4'd3, 32'h1122_3344, 4'b0101);
      bus_read(4'd3);
      checks++;
      if (rdata !== 32'h0022_0044) begin
         errors++; $display("FAIL scratch_be0101: rdata=%h required 00220044", rdata);
      end
      bus_write(4'd3, 32'hAABB_CCDD, 4'b1010);
      bus_read(4'd3);
      checks++;
      if (rdata !== 32'hAA22_CC44) begin
         errors++; $display("FAIL scratch_be1010: rdata=%h required aa22cc44", rdata);
      end
      // Read and write to the same address in one cycle.
      addr = 4'd3; wdata = 32'h5566_7788; be = 4'b1111; rd = 1'b1; wr = 1'b1;
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      checks++;
      if (rdv !== 1'b1 || rdata !== 32'hAA22_CC44) begin
         errors++; $display("FAIL rw_same_cycle: rdv=%b rdata=%h required 1/aa22cc44", rdv, rdata);
      end
      bus_read(4'd3);
      checks++;
      if (rdata !== 32'h5566_7788) begin
         errors++; $display("FAIL rw_after: rdata=%h required 55667788", rdata);
      end
   endtask

   task automatic test_unmapped();
      bus_write(4'd7, 32'hDEAD_BEEF, 4'b1111);
      bus_read(4'd7);
      checks++;
      if (rdv !== 1'b1 || rdata !== 32'h0) begin
         errors++; $display("FAIL read_off7: rdv=%b rdata=%h required 1/0", rdv, rdata);
      end
      bus_read(4'd9);
      checks++;
      if (rdv4 !== 1'b1 || rdata4 !== 32'h0) begin
         errors++; $display("FAIL read_off9_aw4: rdv=%b rdata=%h required 1/0", rdv4, rdata4);
      end
      bus_read(4'd3);
      checks++;
      if (rdata !== 32'h5566_7788) begin
         errors++; $display("FAIL off7_write_ignored: rdata=%h required 55667788", rdata);
      end
   endtask

`ifdef SYSID_UPTIME_EN
   task automatic test_uptime();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      bus_read(4'd4);
      checks++;
      if (rdata !== 32'd100) begin
         errors++; $display("FAIL uptime_lo_idle: rdata=%0d required 100", rdata);
      end
      bus_read(4'd5);
      checks++;
      if (rdata !== 32'h0) begin
         errors++; $display("FAIL uptime_hi_idle: rdata=%h required 0", rdata);
      end
      force dut.u_uptime.cnt_q = 64'h0000_0001_FFFF_FFFF;
      bus_read(4'd4);
      release dut.u_uptime.cnt_q;
      checks++;
      if (rdata !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL uptime_lo_forced: rdata=%h required ffffffff", rdata);
      end
      repeat (3) @(negedge clk);
      bus_read(4'd5);
      checks++;
      if (rdata !== 32'h1) begin
         errors++; $display("FAIL uptime_hi_shadow: rdata=%h required 1", rdata);
      end
   endtask

   task automatic test_clear();
      bus_write(4'd6, 32'h1, 4'b0001);
      repeat (4) @(negedge clk);
      bus_read(4'd4);
      checks++;
      if (rdata !== 32'd4) begin
         errors++; $display("FAIL clear_k5: rdata=%0d required 4", rdata);
      end
      bus_read(4'd5);
      checks++;
      if (rdata !== 32'h0) begin
         errors++; $display("FAIL clear_hi: rdata=%h required 0", rdata);
      end
      bus_write(4'd6, 32'h1, 4'b1110);
      bus_read(4'd4);
      checks++;
      if (rdata !== 32'd7) begin
         errors++; $display("FAIL clear_be_off: rdata=%0d required 7", rdata);
      end
   endtask
`else
   task automatic test_no_uptime();
      bus_read(4'd4);
      checks++;
      if (rdv !== 1'b1 || rdata !== 32'h0) begin
         errors++; $display("FAIL noup_lo: rdv=%b rdata=%h required 1/0", rdv, rdata);
      end
      bus_read(4'd5);
      checks++;
      if (rdv !== 1'b1 || rdata !== 32'h0) begin
         errors++; $display("FAIL noup_hi: rdv=%b rdata=%h required 1/0", rdv, rdata);
      end
      bus_write(4'd6, 32'hFFFF_FFFF, 4'b1111);
      bus_read(4'd6);
      checks++;
      if (rdata !== 32'h0) begin
         errors++; $display("FAIL noup_control: rdata=%h required 0", rdata);
      end
      bus_read(4'd3);
      checks++;
      if (rdata !== 32'h5566_7788) begin
         errors++; $display("FAIL noup_scratch_intact: rdata=%h required 55667788", rdata);
      end
   endtask
`endif

   task automatic test_reset_mid_read();
      bus_write(4'd3, 32'h0BAD_F00D, 4'b1111);
      bus_read(4'd0);
      addr = 4'd1; rd = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      rd = 1'b0;
      checks++;
      if (rdv !== 1'b0 || rdata !== 32'h0) begin
         errors++; $display("FAIL midread_reset: rdv=%b rdata=%h required 0/0", rdv, rdata);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (rdv !== 1'b0) begin
            errors++; $display("FAIL midread_no_pulse: rdv=%b required 0", rdv);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (rdv !== 1'b0) begin
         errors++; $display("FAIL post_reset_rdv: rdv=%b required 0", rdv);
      end
      bus_read(4'd3);
      checks++;
      if (rdv !== 1'b1 || rdata !== 32'h0) begin
         errors++; $display("FAIL scratch_reset: rdv=%b rdata=%h required 1/0", rdv, rdata);
      end
   endtask

   initial begin
      rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'd0; wdata = 32'h0; be = 4'h0;
      test_reset();
      test_ids();
      test_scratch();
      test_unmapped();
`ifdef SYSID_UPTIME_EN
      test_uptime();
      test_clear();
`else
      test_no_uptime();
`endif
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sysid_regs.md
# sysid_regs

Parametrised system-identification slave for the Qsys interconnect: the successor to the fixed two-word ID/timestamp ROM. It adds the following on a registered Avalon-MM read path:
- a capability word;
- a byte-writable scratch register;
- a 64-bit free-running uptime counter with atomic low/high snapshot and software clear.

Host software uses it to confirm the FPGA image, measure elapsed cycles and probe the bus.

## Interface
Parameters:
- ID_VALUE, 0: value returned at word 0.
- TIMESTAMP, 1338190563: build timestamp returned at word 1.
- ADDR_W, 3: word-address width; must be ≥ 3.
- SCRATCH_RESET, 32'h0000_0000: scratch reset value.

Ports:
- clock  in  1  single clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, one cycle per access.
- write  in  1  write strobe, one cycle per access.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high one cycle, marking readdata valid.

## Operation
Register map (word offsets); offsets 7 and above read 0 and ignore writes:
- 0 ID: RO, ID_VALUE.
- 1 TIMESTAMP: RO, TIMESTAMP.
- 2 CAPS: RO.
  - bit0 = uptime present.
  - bits[15:8] = ADDR_W.
  - bits[31:16] = 16'h0002 (block version).
- 3 SCRATCH: RW. Each byte lane is written only where byteenable is set.
- 4 UPTIME_LO: RO, returns counter[31:0]. The same edge loads counter[63:32] into the high shadow.
- 5 UPTIME_HI: RO, returns the high shadow, not the live counter.
- 6 CONTROL: WO, reads 0. Writing bit0 = 1 with byteenable[0] set clears the counter and the shadow. Other bits are ignored.

Behaviour:
- No waitrequest; every access completes.
- Uptime counter: 64-bit, +1 every clock, wraps from all-ones to 0 with no flag.
- Read and write in the same cycle to the same address: the write takes effect; readdata returns the pre-write value.
- Clear and a UPTIME_LO read in the same cycle: the read returns the pre-clear low word. The shadow ends at 0, because clear has priority over the shadow load.

## Timing
- Read latency is fixed at 1: read sampled at edge N gives readdata and readdatavalid=1 after edge N.
- readdatavalid is 0 in every cycle without a preceding read. readdata holds its last value when readdatavalid=0.
- Write latency 1: the register shows the new value from the cycle after the write edge.
- Counter clear: the write at edge N makes counter = 0 after edge N and 1 after edge N+1.
- Reset (asynchronous assert, any time, including mid-access):
  - readdata = 0, readdatavalid = 0;
  - counter = 0, shadow = 0;
  - scratch = SCRATCH_RESET;
  - a pending read is dropped with no readdatavalid.
- First counter increment occurs on the first edge after reset_n deasserts.

## Configuration
- SYSID_UPTIME_EN defined: counter, shadow and CONTROL are present; CAPS bit0 = 1.
- Not defined:
  - no counter or shadow flops are generated;
  - words 4 and 5 read 0;
  - CONTROL writes are ignored;
  - CAPS bit0 = 0.
  - All other behaviour and latency are unchanged.

## Structure
- Package sysid_pkg holds:
  - register offset constants (REG_ID … REG_CONTROL);
  - CAPS version constant 16'h0002;
  - CAPS bit positions.
- Sub-module sysid_uptime contains the counter, shadow, clear/snapshot priority logic, and inputs snap and clr. It is instantiated only under SYSID_UPTIME_EN.
- The top level contains the address decode, scratch register and read-data register.

## Test plan
- Reset, then read words 0, 1 and 2 with ID_VALUE=32'hCAFE0001 and ADDR_W=3 → 32'hCAFE0001, 1338190563, 32'h0002_0301. Each is valid exactly 1 cycle after read.
- Write 32'h11223344 to SCRATCH with byteenable=4'b0101 after reset (SCRATCH_RESET=0), then read → 32'h00220044. Write and read in the same cycle → old value returned.
- Idle 100 cycles after reset, read UPTIME_LO, then UPTIME_HI:
  - LO returns the sampled count (100 ± fixed offset, checked against the bench model);
  - HI returns 0.
  - With the counter preloaded by force to 64'h0000_0001_FFFF_FFFF, a LO read followed by a delayed HI read returns 32'hFFFFFFFF and then 1, not the live high word of 2.
- Write CONTROL=1 → the next UPTIME_LO read issued k cycles later returns k-1. Assert reset_n low mid-read → readdatavalid never pulses and all outputs are 0.
- Build without SYSID_UPTIME_EN → CAPS = 32'h0002_0300; words 4 and 5 read 0; a CONTROL write has no effect. Reads at offset 7 (and at 9 with ADDR_W=4) → 0.
